// File: rtl/add_stream_accumulator_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : add_acc_pkg                                                |
// | Description : Shared constants and types for add_stream_accumulator.     |
// |               DATA_W   - operand / sum width                             |
// |               BLOCK_W  - carry-select block width inside the adder       |
// |               acc_state_t - frame state (ACC collects, OUT holds result) |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package add_acc_pkg;

   localparam int DATA_W  = 16;
   localparam int BLOCK_W = 4;

   typedef enum logic [0:0] {
      ACC = 1'b0,
      OUT = 1'b1
   } acc_state_t;

endpackage : add_acc_pkg
`default_nettype wire

// File: rtl/add_stream_accumulator_csa.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : CarrySelectAdder                                           |
// | Description : WIDTH-bit carry-select adder. Each BLOCK_W slice computes  |
// |               its sum for both possible carry-ins in parallel; the real  |
// |               block carry then only drives a mux, so the critical path   |
// |               is one slice plus a chain of muxes.                        |
// | Ports       : a, b   in  WIDTH  operands                                 |
// |               cin    in  1      carry in                                 |
// |               sum    out WIDTH  a + b + cin (mod 2^WIDTH)                 |
// |               cout   out 1      carry out of the top bit                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module CarrySelectAdder #(
   parameter int WIDTH   = 16,
   parameter int BLOCK_W = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int NUM_BLK = WIDTH / BLOCK_W;

   // blk_carry[k] is the carry entering slice k; blk_carry[NUM_BLK] is cout.
   logic [NUM_BLK:0] blk_carry;

   assign blk_carry[0] = cin;

   for (genvar k = 0; k < NUM_BLK; k++) begin : g_blk
      logic [BLOCK_W:0]   res0;
      logic [BLOCK_W:0]   res1;
      logic [BLOCK_W-1:0] a_s;
      logic [BLOCK_W-1:0] b_s;

      assign a_s  = a[k*BLOCK_W +: BLOCK_W];
      assign b_s  = b[k*BLOCK_W +: BLOCK_W];
      assign res0 = {1'b0, a_s} + {1'b0, b_s};
      assign res1 = {1'b0, a_s} + {1'b0, b_s} + {{BLOCK_W{1'b0}}, 1'b1};

      assign sum[k*BLOCK_W +: BLOCK_W] = blk_carry[k] ? res1[BLOCK_W-1:0]
                                                      : res0[BLOCK_W-1:0];
      assign blk_carry[k+1]            = blk_carry[k] ? res1[BLOCK_W]
                                                      : res0[BLOCK_W];
   end : g_blk

   assign cout = blk_carry[NUM_BLK];

endmodule : CarrySelectAdder
`default_nettype wire

// File: rtl/add_stream_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : add_stream_accumulator                                     |
// | Description : Folds a valid/ready stream of 16-bit operands into a       |
// |               running sum, one frame at a time (frame ends on in_last),  |
// |               and presents sum / carry count / operand count on a        |
// |               valid/ready result port. Counters saturate at 2^CNT_W-1.   |
// | Config      : ADD_ACC_SUBTRACT_EN - adds in_sub; an accept with in_sub=1 |
// |               subtracts in_data and counts borrows instead of carries.   |
// | Ports       : clk, rst (sync, active high)                               |
// |               in_valid/in_ready/in_data/in_last [/in_sub]  operand input |
// |               out_valid/out_ready/out_sum/out_carry_cnt/out_op_cnt       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module add_stream_accumulator
   import add_acc_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
`ifdef ADD_ACC_SUBTRACT_EN
   input  logic              in_sub,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_sum,
   output logic [CNT_W-1:0]  out_carry_cnt,
   output logic [CNT_W-1:0]  out_op_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   acc_state_t        state;
   acc_state_t        state_next;

   logic [DATA_W-1:0] acc;
   logic [CNT_W-1:0]  carry_cnt;
   logic [CNT_W-1:0]  op_cnt;

   logic              accept;
   logic [DATA_W-1:0] add_b;
   logic              add_cin;
   logic [DATA_W-1:0] add_sum;
   logic              add_cout;
   logic              carry_event;
   logic [CNT_W-1:0]  carry_cnt_next;
   logic [CNT_W-1:0]  op_cnt_next;

   // Operand conditioning: subtraction is acc + ~d + 1, where a missing
   // carry out means the result borrowed.
`ifdef ADD_ACC_SUBTRACT_EN
   assign add_b       = in_sub ? ~in_data : in_data;
   assign add_cin     = in_sub;
   assign carry_event = in_sub ? ~add_cout : add_cout;
`else
   assign add_b       = in_data;
   assign add_cin     = 1'b0;
   assign carry_event = add_cout;
`endif

   CarrySelectAdder #(
      .WIDTH   (DATA_W),
      .BLOCK_W (BLOCK_W)
   ) u_adder (
      .a    (acc),
      .b    (add_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Saturating counter updates; they only matter on an accept.
   assign carry_cnt_next = (carry_event && (carry_cnt != CNT_MAX))
                           ? carry_cnt + CNT_ONE : carry_cnt;
   assign op_cnt_next    = (op_cnt != CNT_MAX) ? op_cnt + CNT_ONE : op_cnt;

   // Handshake outputs are a pure function of state, so in_ready never
   // sees out_ready combinationally.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         ACC: begin
            in_ready = 1'b1;
            if (in_valid && in_last) begin
               state_next = OUT;
            end
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = ACC;
            end
         end
         default: begin
            state_next = ACC;
         end
      endcase
   end

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ACC;
      end else begin
         state <= state_next;
      end
   end

   // Running accumulator and counters. On the last operand they clear in
   // the same edge that loads the result bank, so the next frame can start
   // immediately after the result is taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         carry_cnt <= '0;
         op_cnt    <= '0;
      end else if (accept) begin
         if (in_last) begin
            acc       <= '0;
            carry_cnt <= '0;
            op_cnt    <= '0;
         end else begin
            acc       <= add_sum;
            carry_cnt <= carry_cnt_next;
            op_cnt    <= op_cnt_next;
         end
      end
   end

   // Result bank: loaded only on the last accept, held through OUT.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_sum       <= '0;
         out_carry_cnt <= '0;
         out_op_cnt    <= '0;
      end else if (accept && in_last) begin
         out_sum       <= add_sum;
         out_carry_cnt <= carry_cnt_next;
         out_op_cnt    <= op_cnt_next;
      end
   end

endmodule : add_stream_accumulator
`default_nettype wire

// File: tb/tb_add_stream_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_add_stream_accumulator                                  |
// | Description : Scoreboard bench. Two instances (CNT_W=8 and CNT_W=2) see  |
// |               the same stream; expected frame results are computed from  |
// |               whole-frame arithmetic and queued, and a monitor compares  |
// |               them whenever out_valid is high.                           |
// | Config      : ADD_ACC_SUBTRACT_EN - also drives in_sub.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_add_stream_accumulator;

   typedef struct {
      logic [15:0] sum;
      int          carry;
      int          op;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_last;
   logic        in_sub;
   logic        out_ready;

   logic        in_ready8, out_valid8;
   logic [15:0] out_sum8;
   logic [7:0]  out_carry8, out_op8;
   logic        in_ready2, out_valid2;
   logic [15:0] out_sum2;
   logic [1:0]  out_carry2, out_op2;

   int   checks   = 0;
   int   failures = 0;
   exp_t q8[$];
   exp_t q2[$];
   bit   rdy_random = 1'b1;

   always #5 clk = ~clk;

   add_stream_accumulator #(.CNT_W(8)) u_dut8 (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready8),
      .in_data       (in_data),
      .in_last       (in_last),
`ifdef ADD_ACC_SUBTRACT_EN
      .in_sub        (in_sub),
`endif
      .out_valid     (out_valid8),
      .out_ready     (out_ready),
      .out_sum       (out_sum8),
      .out_carry_cnt (out_carry8),
      .out_op_cnt    (out_op8)
   );

   add_stream_accumulator #(.CNT_W(2)) u_dut2 (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready2),
      .in_data       (in_data),
      .in_last       (in_last),
`ifdef ADD_ACC_SUBTRACT_EN
      .in_sub        (in_sub),
`endif
      .out_valid     (out_valid2),
      .out_ready     (out_ready),
      .out_sum       (out_sum2),
      .out_carry_cnt (out_carry2),
      .out_op_cnt    (out_op2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: whole-frame arithmetic on plain integers.
   function automatic exp_t model(input logic [15:0] ops[$], input bit subs[$], input int w);
      int   acc  = 0;
      int   c    = 0;
      int   maxv = (1 << w) - 1;
      exp_t e;
      foreach (ops[i]) begin
         if (subs[i]) begin
            if (acc < int'(ops[i])) c++;
            acc = acc - int'(ops[i]);
            if (acc < 0) acc += 65536;
         end else begin
            acc = acc + int'(ops[i]);
            if (acc > 65535) begin
               c++;
               acc -= 65536;
            end
         end
      end
      e.sum   = acc[15:0];
      e.carry = (c > maxv) ? maxv : c;
      e.op    = (ops.size() > maxv) ? maxv : ops.size();
      return e;
   endfunction

   // Consumer: random backpressure unless the sequence takes over out_ready.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_random) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: compare every cycle a result is presented; pop when taken.
   always @(negedge clk) begin
      if (!rst) begin
         check("in_ready8_vs_state", in_ready8, !out_valid8);
         check("in_ready2_vs_state", in_ready2, !out_valid2);
         if (out_valid8) begin
            if (q8.size() == 0) check("spurious_out8", out_valid8, 1'b0);
            else begin
               check("sum8",   out_sum8,   q8[0].sum);
               check("carry8", out_carry8, q8[0].carry);
               check("op8",    out_op8,    q8[0].op);
               if (out_ready) void'(q8.pop_front());
            end
         end
         if (out_valid2) begin
            if (q2.size() == 0) check("spurious_out2", out_valid2, 1'b0);
            else begin
               check("sum2",   out_sum2,   q2[0].sum);
               check("carry2", out_carry2, q2[0].carry);
               check("op2",    out_op2,    q2[0].op);
               if (out_ready) void'(q2.pop_front());
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic drive_op(input logic [15:0] d, input logic l, input bit s);
      int guard = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      in_sub   = s;
      while (!in_ready8 && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 300) check("in_ready_timeout", in_ready8, 1'b1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      in_last  = 1'($urandom);
      in_sub   = 1'($urandom);
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         in_valid = 1'b0;
         in_data  = 16'($urandom);
         in_last  = 1'($urandom);
         @(negedge clk);
      end
   endtask

   task automatic send_frame(input logic [15:0] ops[$], input bit subs[$], input bit gaps);
      for (int i = 0; i < ops.size(); i++) begin
         if (gaps) idle_cycles($urandom_range(0, 2));
         if (i == ops.size() - 1) begin
            q8.push_back(model(ops, subs, 8));
            q2.push_back(model(ops, subs, 2));
         end
         drive_op(ops[i], (i == ops.size() - 1), subs[i]);
      end
      // First cycle after the last accept: result up, input closed.
      check("latency_out_valid", out_valid8, 1'b1);
      check("gap_in_ready", in_ready8, 1'b0);
   endtask

   task automatic drain();
      int guard = 0;
      while ((q8.size() != 0 || q2.size() != 0 || out_valid8) && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      check("drain_timeout", 32'(q8.size()), 32'd0);
   endtask

   initial begin
      logic [15:0] ops[$];
      bit          subs[$];
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      in_sub   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid8, 1'b0);
      check("rst_out_sum",   out_sum8,   16'h0);
      check("rst_out_carry", out_carry8, 8'h0);
      check("rst_out_op",    out_op8,    8'h0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", in_ready8, 1'b1);

      // Directed frames.
      ops = '{16'h0001, 16'h0002, 16'h0003}; subs = '{0, 0, 0};
      send_frame(ops, subs, 1'b0);
      drain();
      ops = '{16'hFFFF, 16'h0002};           subs = '{0, 0};
      send_frame(ops, subs, 1'b0);
      drain();
      ops = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
      subs = '{0, 0, 0, 0, 0, 0};
      send_frame(ops, subs, 1'b0);
      drain();

      // Held result under backpressure, single-operand frame.
      rdy_random = 1'b0;
      out_ready  = 1'b0;
      ops = '{16'hABCD}; subs = '{0};
      send_frame(ops, subs, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("hold_out_valid", out_valid8, 1'b1);
         check("hold_in_ready",  in_ready8,  1'b0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("release_in_ready", in_ready8, 1'b1);
      out_ready = 1'b0;
      ops = '{16'h0007, 16'h0008}; subs = '{0, 0};
      out_ready = 1'b1;
      send_frame(ops, subs, 1'b0);
      drain();
      rdy_random = 1'b1;

      // Reset mid-frame discards the partial sum.
      drive_op(16'h0010, 1'b0, 1'b0);
      drive_op(16'h0020, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", out_valid8, 1'b0);
      check("midrst_out_sum",   out_sum8,   16'h0);
      ops = '{16'h0005}; subs = '{0};
      send_frame(ops, subs, 1'b0);
      drain();

`ifdef ADD_ACC_SUBTRACT_EN
      ops = '{16'h0003, 16'h0005}; subs = '{0, 1};
      send_frame(ops, subs, 1'b0);
      drain();
`endif

      // Randomized frames.
      for (int f = 0; f < 40; f++) begin
         int n = $urandom_range(1, 8);
         ops.delete();
         subs.delete();
         for (int i = 0; i < n; i++) begin
            ops.push_back(($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
`ifdef ADD_ACC_SUBTRACT_EN
            subs.push_back(1'($urandom));
`else
            subs.push_back(1'b0);
`endif
         end
         send_frame(ops, subs, 1'b1);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_add_stream_accumulator
`default_nettype wire
